// File: rtl/store_drain_buffer.sv
// store_drain_buffer: in-order FIFO between retire and the data-memory write
// port. Each retired store is captured into a slot and drained over a
// mem_req/mem_gnt handshake. Write data and byte enables are lane-shifted by
// addr[2:0]. Optional store-to-load forwarding search: define STORE_FWD_EN.

package store_drain_pkg;
  // Retired LSQ entry; only addr and data are consumed by the drain buffer.
  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  rob_id;
  } lsq_entry;
endpackage

// One buffered store. Payload is never reset: validity is tracked by the
// head pointer and occupancy count in the parent.
module sdb_slot #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [3:0]        wr_size,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic [3:0]        size
);
  // capture the retiring store when this slot is the tail
  always_ff @(posedge clk) begin
    if (wr_en) begin
      addr <= wr_addr;
      data <= wr_data;
      size <= wr_size;
    end
  end
endmodule

module store_drain_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      lsq_decrement,
  input  store_drain_pkg::lsq_entry le,
  input  logic [31:0]               le_size,
  output logic                      retire_stall,
  output logic                      mem_req,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic [DATA_W/8-1:0]       mem_be,
  input  logic                      mem_gnt,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
`ifdef STORE_FWD_EN
  ,
  input  logic [ADDR_W-1:0]         fwd_addr,
  output logic                      fwd_hit,
  output logic [DATA_W-1:0]         fwd_data
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BE_W  = DATA_W / 8;
  localparam int MW    = 2 * BE_W;

  typedef enum logic [0:0] {IDLE, REQ} state_t;

  state_t                         state;
  logic [PTR_W-1:0]               rd_ptr, wr_ptr, ld_idx;
  logic                           push, pop;
  logic [DEPTH-1:0]               slot_we;
  logic [DEPTH-1:0][ADDR_W-1:0]   slot_addr;
  logic [DEPTH-1:0][DATA_W-1:0]   slot_data;
  logic [DEPTH-1:0][3:0]          slot_size;
  logic [ADDR_W-1:0]              ld_addr;
  logic [DATA_W-1:0]              ld_wdata;
  logic [BE_W-1:0]                ld_be;
  logic                           unused_le;

  assign unused_le = ^le.rob_id;

  // Byte enables: size-byte mask shifted to the lane offset; bytes past the
  // doubleword are simply dropped by the truncation.
  function automatic logic [BE_W-1:0] fmt_be(input logic [2:0] off, input logic [3:0] sz);
    logic [MW-1:0] m;
    m = (MW'(1) << sz) - MW'(1);
    m = m << off;
    return m[BE_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] fmt_data(input logic [DATA_W-1:0] d, input logic [2:0] off);
    return d << {off, 3'b000};
  endfunction

  // Loads retiring (size 0) never occupy a slot. Full is guarded by the stall.
  assign push         = lsq_decrement && (le_size != 32'd0) && !retire_stall;
  assign pop          = mem_req && mem_gnt;
  assign retire_stall = (count == CNT_W'(DEPTH));
  assign empty        = (count == '0);
  assign slot_we      = push ? (DEPTH'(1) << wr_ptr) : '0;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    sdb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot (
      .clk     (clk),
      .wr_en   (slot_we[i]),
      .wr_addr (le.addr[ADDR_W-1:0]),
      .wr_data (le.data[DATA_W-1:0]),
      .wr_size (le_size[3:0]),
      .addr    (slot_addr[i]),
      .data    (slot_data[i]),
      .size    (slot_size[i])
    );
  end

  // IDLE presents the head; a granted REQ presents the entry behind it.
  assign ld_idx   = (state == IDLE) ? rd_ptr : rd_ptr + PTR_W'(1);
  assign ld_addr  = {slot_addr[ld_idx][ADDR_W-1:3], 3'b000};
  assign ld_be    = fmt_be(slot_addr[ld_idx][2:0], slot_size[ld_idx]);
  assign ld_wdata = fmt_data(slot_data[ld_idx], slot_addr[ld_idx][2:0]);

  // tail pointer and occupancy; push and pop in one cycle cancel out
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // drain FSM: registered request held stable until granted, then either
  // chain straight into the next stored entry or fall back to IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            state     <= REQ;
            mem_req   <= 1'b1;
            mem_addr  <= ld_addr;
            mem_wdata <= ld_wdata;
            mem_be    <= ld_be;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
            // only entries already in the buffer chain; a same-cycle push
            // is picked up from IDLE on the following edge
            if (count > CNT_W'(1)) begin
              mem_addr  <= ld_addr;
              mem_wdata <= ld_wdata;
              mem_be    <= ld_be;
            end else begin
              state   <= IDLE;
              mem_req <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef STORE_FWD_EN
  // walk oldest to youngest so the youngest full-doubleword match wins
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx      = '0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < count) && (slot_addr[idx] == fwd_addr) && (slot_size[idx] == 4'd8)) begin
        fwd_hit  = 1'b1;
        fwd_data = slot_data[idx];
      end
    end
  end
`endif

  // retire must honour retire_stall; a store arriving while full is lost
  a_no_push_full: assert property (@(posedge clk) disable iff (!reset)
    !(lsq_decrement && (le_size != 32'd0) && retire_stall));

endmodule

// File: tb/tb_store_drain_buffer.sv
// Bench for store_drain_buffer: a reference model updated each clock edge
// pushes expected memory writes into a scoreboard; a negedge monitor pops and
// compares whenever the DUT completes a handshake. Define STORE_FWD_EN to
// also cover the forwarding search.
module tb_store_drain_buffer;
  import store_drain_pkg::*;
  localparam int DEPTH = 4;

  logic        clk = 1'b0, reset = 1'b0, lsq_decrement = 1'b0, mem_gnt = 1'b0;
  lsq_entry    le = '0;
  logic [31:0] le_size = '0;
  logic        retire_stall, mem_req, empty;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_be;
  logic [2:0]  count;
`ifdef STORE_FWD_EN
  logic [63:0] fwd_addr = '0, fwd_data;
  logic        fwd_hit;
`endif

  always #5 clk = ~clk;

  store_drain_buffer #(.DEPTH(DEPTH), .ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .reset(reset), .lsq_decrement(lsq_decrement), .le(le), .le_size(le_size),
    .retire_stall(retire_stall), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt), .empty(empty), .count(count)
`ifdef STORE_FWD_EN
    , .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
  );

  typedef struct { logic [63:0] addr; logic [63:0] data; int size; int pedge; } ment_t;
  typedef struct { logic [63:0] addr; logic [63:0] wdata; logic [7:0] be; } txn_t;

  ment_t m_ent[$];   // model contents, oldest first
  txn_t  exp_q[$];   // scoreboard of expected memory writes
  bit    m_req = 1'b0;
  int    edge_no = 0, nvec = 0, nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // expected write: doubleword address, data and mask shifted by byte offset
  function automatic txn_t fmt(input logic [63:0] a, input logic [63:0] d, input int sz);
    txn_t t;
    longint unsigned off, bf;
    off     = a % 64'd8;
    t.addr  = a - off;
    bf      = ((64'd1 << sz) - 64'd1) << off;
    t.be    = bf[7:0];
    t.wdata = d << (8 * off);
    return t;
  endfunction

  task automatic model_clear();
    m_ent.delete();
    exp_q.delete();
    m_req = 1'b0;
  endtask

  // reference model: a store becomes visible on the edge after its push and
  // leaves when granted while visible
  always @(posedge clk) begin
    bit pop, push;
    ment_t e;
    edge_no++;
    if (!reset) model_clear();
    else begin
      pop  = m_req && mem_gnt;
      push = lsq_decrement && (le_size != 0) && (m_ent.size() < DEPTH);
      if (pop) m_ent.delete(0);
      if (push) begin
        e.addr = le.addr; e.data = le.data; e.size = int'(le_size); e.pedge = edge_no;
        m_ent.push_back(e);
        exp_q.push_back(fmt(le.addr, le.data, int'(le_size)));
      end
      m_req = (m_ent.size() > 0) && (m_ent[0].pedge < edge_no);
    end
  end

  // monitor: status every cycle, write payload on each handshake
  always @(negedge clk) begin
    txn_t t;
    if (reset) begin
      chk("mem_req", 64'(mem_req), 64'(m_req));
      chk("count", 64'(count), 64'(m_ent.size()));
      chk("empty", 64'(empty), 64'(m_ent.size() == 0));
      chk("retire_stall", 64'(retire_stall), 64'(m_ent.size() == DEPTH));
      if (mem_req && mem_gnt) begin
        if (exp_q.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL sb_underflow: got write %0h expected none", mem_addr);
        end else begin
          t = exp_q.pop_front();
          chk("mem_addr", mem_addr, t.addr);
          chk("mem_wdata", mem_wdata, t.wdata);
          chk("mem_be", 64'(mem_be), 64'(t.be));
        end
      end
`ifdef STORE_FWD_EN
      begin
        bit hit; logic [63:0] d;
        hit = 1'b0; d = '0;
        foreach (m_ent[i]) if (m_ent[i].addr == fwd_addr && m_ent[i].size == 8) begin hit = 1'b1; d = m_ent[i].data; end
        chk("fwd_hit", 64'(fwd_hit), 64'(hit));
        if (hit) chk("fwd_data", fwd_data, d);
      end
`endif
    end
  end

  // one cycle of retire/memory stimulus; retire honours the stall
  task automatic drive(input bit dec, input logic [63:0] a, input logic [63:0] d,
                       input logic [31:0] sz, input bit g);
    if (dec && sz != 0 && m_ent.size() >= DEPTH) dec = 1'b0;
    lsq_decrement = dec; le.addr = a; le.data = d; le.rob_id = 8'($urandom);
    le_size = sz; mem_gnt = g;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((m_ent.size() != 0 || m_req) && n < 50) begin drive(0, 0, 0, 0, 1); n++; end
    if (n >= 50) begin nvec++; nerr++; $display("FAIL drain_timeout: got %0d left expected 0", m_ent.size()); end
    drive(0, 0, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    int sizes[5] = '{0, 1, 2, 4, 8};
    logic [63:0] a;
    int sz;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // reset mid-drain must clear outputs without waiting for a clock
    drive(1, 64'h100, 64'h11, 8, 0);
    drive(1, 64'h108, 64'h22, 8, 0);
    drive(0, 0, 0, 0, 0);
    #2 reset = 1'b0; model_clear();
    #1;
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_mem_be", 64'(mem_be), 64'd0);
    chk("rst_stall", 64'(retire_stall), 64'd0);
    @(posedge clk); #1 reset = 1'b1;

    // single misaligned byte store; gnt while idle is ignored
    drive(1, 64'h1003, 64'hAB, 1, 0);
    chk("single_req_latency", 64'(mem_req), 64'd0);
    drive(0, 0, 0, 0, 1);
    chk("single_req", 64'(mem_req), 64'd1);
    chk("single_addr", mem_addr, 64'h1000);
    chk("single_be", 64'(mem_be), 64'h08);
    chk("single_wdata", mem_wdata, 64'hAB000000);
    drive(0, 0, 0, 0, 1);
    chk("single_empty", 64'(empty), 64'd1);
    drive(0, 0, 0, 0, 0);

    // fill and stall, then one grant frees a slot
    for (int i = 0; i < 4; i++) drive(1, 64'h3000 + 64'(8 * i) + 64'(i), {$urandom, $urandom}, 32'(sizes[1 + i]), 0);
    chk("full_count", 64'(count), 64'd4);
    chk("full_stall", 64'(retire_stall), 64'd1);
    drive(0, 0, 0, 0, 1);
    chk("after_gnt_count", 64'(count), 64'd3);
    chk("after_gnt_stall", 64'(retire_stall), 64'd0);
    drain();

    // back-to-back drain with grant held high
    hi = 0;
    for (int i = 0; i < 3; i++) begin drive(1, 64'h5000 + 64'(16 * i), 64'(i + 1), 8, 1); hi += int'(mem_req); end
    for (int i = 0; i < 4; i++) begin drive(0, 0, 0, 0, 1); hi += int'(mem_req); end
    chk("b2b_req_cycles", 64'(hi), 64'd3);

    // load filter and simultaneous push/pop at count 2
    drive(1, 64'h6000, 64'h1, 2, 0);
    drive(1, 64'h6008, 64'h2, 4, 0);
    drive(1, 64'h6010, 64'h3, 0, 0);
    chk("load_ignored", 64'(count), 64'd2);
    drive(1, 64'h6018, 64'h4, 8, 1);
    chk("push_pop_count", 64'(count), 64'd2);
    drain();

`ifdef STORE_FWD_EN
    drive(1, 64'h2000, 64'd1, 8, 0);
    drive(1, 64'h2000, 64'd2, 8, 0);
    fwd_addr = 64'h2000; #1;
    chk("fwd_young_hit", 64'(fwd_hit), 64'd1);
    chk("fwd_young_data", fwd_data, 64'd2);
    fwd_addr = 64'h2008; #1;
    chk("fwd_miss", 64'(fwd_hit), 64'd0);
    drain();
`endif

    // randomized traffic: a fill-heavy phase then a drain-heavy phase
    for (int c = 0; c < 3000; c++) begin
      sz = sizes[$urandom_range(0, 4)];
      a  = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'h4000 + 64'($urandom_range(0, 31));
`ifdef STORE_FWD_EN
      fwd_addr = 64'h4000 + 64'(8 * $urandom_range(0, 3));
`endif
      drive(bit'($urandom_range(0, 1)), a, {$urandom, $urandom}, 32'(sz),
            (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
    end
    drain();
    chk("sb_leftover", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
